// File: rtl/sample_streamer_pkg.sv
// sample_streamer_pkg: shared types and constant functions for sample_streamer.
//   state_t / St*  : streamer FSM encoding
//   field_width    : bits needed to hold values 0..v-1 (never less than 1)
//   addr_width     : width of the memory read address
//   num_width      : width of the emitted-sample index
//   pad_count      : zero samples needed to round a run up to a whole frame
package sample_streamer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StRead  = 2'd1;
  localparam state_t StFlush = 2'd2;
  localparam state_t StPad   = 2'd3;

  function automatic int unsigned field_width(input int unsigned v);
    return (v < 2) ? 1 : unsigned'($clog2(v));
  endfunction

  function automatic int unsigned addr_width(input int unsigned total);
    return field_width(total);
  endfunction

  function automatic int unsigned num_width(input int unsigned total, input int unsigned frame);
    return field_width(total + frame);
  endfunction

  function automatic int unsigned pad_count(input int unsigned total, input int unsigned frame);
    return ((total + frame - 1) / frame) * frame - total;
  endfunction

endpackage

// File: rtl/sample_streamer_if.sv
// sample_streamer_if: control, sample-memory and output-stream signals of sample_streamer.
//   start, hold          : run control into the streamer
//   mem_rd, mem_addr     : read request to the sample memory
//   mem_data             : read data, valid the cycle after mem_rd
//   do_en, data_o, num   : emitted sample strobe, value and zero-based index
//   busy, done           : run in progress / final-sample pulse
// master = the streamer, slave = its environment.
interface sample_streamer_if
  import sample_streamer_pkg::*;
#(
  parameter int unsigned I_BW       = 14,
  parameter int unsigned O_BW       = 14,
  parameter int unsigned TOTAL_DATA = 15104,
  parameter int unsigned FRAME_LEN  = 512
) ();

  localparam int unsigned AW = addr_width(TOTAL_DATA);
  localparam int unsigned NW = num_width(TOTAL_DATA, FRAME_LEN);

  logic            start;
  logic            hold;
  logic            mem_rd;
  logic [AW-1:0]   mem_addr;
  logic [I_BW-1:0] mem_data;
  logic            do_en;
  logic [O_BW-1:0] data_o;
  logic [NW-1:0]   num;
  logic            busy;
  logic            done;

  modport master (
    input  start, hold, mem_data,
    output mem_rd, mem_addr, do_en, data_o, num, busy, done
  );

  modport slave (
    output start, hold, mem_data,
    input  mem_rd, mem_addr, do_en, data_o, num, busy, done
  );

endinterface

// File: rtl/sample_addr_gen.sv
// sample_addr_gen: sequential read-address generator for sample_streamer.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart the sequence at address 0 (same-cycle en issues address 0)
//   en       : issue the next address this cycle (hold gating is done by the caller)
//   mem_rd   : registered read strobe
//   mem_addr : registered read address, held while not issuing
//   tc       : the address that would be issued now is the last one of the run
module sample_addr_gen #(
  parameter int unsigned TOTAL_DATA = 15104,
  parameter int unsigned AW         = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic          tc
);

  localparam logic [AW-1:0] LastAddr = AW'(TOTAL_DATA - 1);

  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cur;

  // A clear takes effect in the same cycle so a run can issue address 0 immediately.
  assign cur = clear ? '0 : cnt_q;
  assign tc  = (cur == LastAddr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_rd <= en;
      if (en) begin
        mem_addr <= cur;
        cnt_q    <= cur + AW'(1);
      end else if (clear) begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/sample_streamer.sv
// sample_streamer: reads TOTAL_DATA samples from a sample memory and streams them out
// sign-extended, with a running index, optionally padding with zeros to a whole frame.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sample_streamer_if.master (start/hold in, memory port, output stream)
// Build option: define SAMPLE_STREAMER_PAD_EN to append zero samples after the last read
// until the emitted count is a multiple of FRAME_LEN; otherwise exactly TOTAL_DATA samples.
// Pipeline: issue decision -> mem_rd/mem_addr (reg) -> memory -> data_o/do_en (reg).
module sample_streamer
  import sample_streamer_pkg::*;
#(
  parameter int unsigned I_BW       = 14,
  parameter int unsigned O_BW       = 14,
  parameter int unsigned TOTAL_DATA = 15104,
  parameter int unsigned FRAME_LEN  = 512
) (
  input logic               clk,
  input logic               rst,
  sample_streamer_if.master bus
);

  localparam int unsigned AW = addr_width(TOTAL_DATA);
  localparam int unsigned NW = num_width(TOTAL_DATA, FRAME_LEN);
  localparam logic [AW-1:0] LastAddr = AW'(TOTAL_DATA - 1);

  state_t state_q, state_d;

  logic          accept;
  logic          issue;
  logic          tc;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;

  // Stage between the read strobe and the returning memory data.
  logic          rd_p_q;
  logic [AW-1:0] addr_p_q;
  logic          last_emit;
  logic          read_final;

  logic            do_en_q;
  logic            done_q;
  logic            busy_q;
  logic [O_BW-1:0] data_q;
  logic [NW-1:0]   num_q;

`ifdef SAMPLE_STREAMER_PAD_EN
  localparam int unsigned PadCnt = pad_count(TOTAL_DATA, FRAME_LEN);
  localparam int unsigned PW     = field_width(PadCnt + 1);

  logic [PW-1:0] pad_cnt_q;
  logic          pad_fire;
  logic          pad_last;

  assign pad_fire   = (state_q == StPad) && !bus.hold && (pad_cnt_q != PW'(PadCnt));
  assign pad_last   = (pad_cnt_q == PW'(PadCnt - 1));
  assign read_final = last_emit && (PadCnt == 0);
`else
  assign read_final = last_emit;
`endif

  assign accept    = (state_q == StIdle) && bus.start;
  assign issue     = (accept || (state_q == StRead)) && !bus.hold;
  assign last_emit = rd_p_q && (addr_p_q == LastAddr);

  sample_addr_gen #(
    .TOTAL_DATA (TOTAL_DATA),
    .AW         (AW)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .en       (issue),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .tc       (tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.start) state_d = (issue && tc) ? StFlush : StRead;
      end
      StRead: begin
        if (issue && tc) state_d = StFlush;
      end
      StFlush: begin
        // done_q marks the cycle of the final do_en; leave the cycle after it.
        if (done_q) begin
          state_d = StIdle;
`ifdef SAMPLE_STREAMER_PAD_EN
        end else if (last_emit && (PadCnt != 0)) begin
          state_d = StPad;
`endif
        end
      end
`ifdef SAMPLE_STREAMER_PAD_EN
      StPad: begin
        if (done_q) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_p_q   <= 1'b0;
      addr_p_q <= '0;
      do_en_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      data_q   <= '0;
      num_q    <= '0;
`ifdef SAMPLE_STREAMER_PAD_EN
      pad_cnt_q <= '0;
`endif
    end else begin
      rd_p_q   <= mem_rd;
      addr_p_q <= mem_addr;
      do_en_q  <= 1'b0;
      done_q   <= 1'b0;
      if (accept) busy_q <= 1'b1;
      if (rd_p_q) begin
        do_en_q <= 1'b1;
        data_q  <= O_BW'($signed(bus.mem_data));
        num_q   <= NW'(addr_p_q);
        if (read_final) begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
      end
`ifdef SAMPLE_STREAMER_PAD_EN
      if (accept) pad_cnt_q <= '0;
      // Pads only start once every read has been emitted, so num simply counts on.
      if (pad_fire) begin
        do_en_q   <= 1'b1;
        data_q    <= '0;
        num_q     <= num_q + NW'(1);
        pad_cnt_q <= pad_cnt_q + PW'(1);
        if (pad_last) begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
      end
`endif
    end
  end

  assign bus.mem_rd   = mem_rd;
  assign bus.mem_addr = mem_addr;
  assign bus.do_en    = do_en_q;
  assign bus.data_o   = data_q;
  assign bus.num      = num_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_sample_streamer.sv
// tb_sample_streamer: randomized self-checking bench for sample_streamer
// (TOTAL_DATA=10, FRAME_LEN=4, I_BW=14, O_BW=16). Expected output stream is built from the
// memory contents by plain arithmetic; honours SAMPLE_STREAMER_PAD_EN like the design.
module tb_sample_streamer;

  localparam int unsigned IBW = 14;
  localparam int unsigned OBW = 16;
  localparam int unsigned TD  = 10;
  localparam int unsigned FL  = 4;
`ifdef SAMPLE_STREAMER_PAD_EN
  localparam int ETOT = ((TD + FL - 1) / FL) * FL;
`else
  localparam int ETOT = TD;
`endif

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  logic [IBW-1:0] mem [TD];
  int unsigned    exp_data [ETOT];

  sample_streamer_if #(
    .I_BW       (IBW),
    .O_BW       (OBW),
    .TOTAL_DATA (TD),
    .FRAME_LEN  (FL)
  ) ss_if ();

  sample_streamer #(
    .I_BW       (IBW),
    .O_BW       (OBW),
    .TOTAL_DATA (TD),
    .FRAME_LEN  (FL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ss_if)
  );

  always #5 clk = ~clk;

  // Sample memory: one-cycle read latency.
  always @(posedge clk) begin
    if (ss_if.mem_rd) ss_if.mem_data <= mem[ss_if.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned sext(input int unsigned v);
    if (v >= (1 << (IBW - 1))) return v + (1 << OBW) - (1 << IBW);
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_rd"},   32'(ss_if.mem_rd), 0);
    check({tag, "_mem_addr"}, 32'(ss_if.mem_addr), 0);
    check({tag, "_do_en"},    32'(ss_if.do_en), 0);
    check({tag, "_data_o"},   32'(ss_if.data_o), 0);
    check({tag, "_num"},      32'(ss_if.num), 0);
    check({tag, "_busy"},     32'(ss_if.busy), 0);
    check({tag, "_done"},     32'(ss_if.done), 0);
  endtask

  // hold_pct: 0 = no hold, >0 = random hold percentage, <0 = 3-cycle hold after address 3.
  // start_at / rst_at: emitted index at which to pulse start / assert reset (-1 = never).
  task automatic run_one(input int hold_pct, input int start_at, input int rst_at,
                         input bit neg_first);
    int idx = 0;
    int quiet = 0;
    int hold_left = 0;
    for (int i = 0; i < TD; i++) mem[i] = IBW'($urandom);
    if (neg_first) mem[0] = 14'h2000;
    for (int i = 0; i < ETOT; i++) exp_data[i] = (i < TD) ? sext(32'(mem[i])) : 0;
    @(negedge clk);
    ss_if.start = 1'b1;
    ss_if.hold  = 1'b0;
    for (int k = 1; k < 400 && quiet < 4; k++) begin
      @(negedge clk);
      ss_if.start = 1'b0;
      if (ss_if.do_en) begin
        if (idx >= ETOT) begin
          check("extra_do_en", 1, 0);
        end else begin
          if (hold_pct <= 0)
            check("emit_cycle", k, 3 + idx + ((hold_pct < 0 && idx >= 4) ? 3 : 0));
          check("data_o", 32'(ss_if.data_o), exp_data[idx]);
          check("num", 32'(ss_if.num), idx);
          check("done", 32'(ss_if.done), (idx == ETOT - 1) ? 1 : 0);
          check("busy", 32'(ss_if.busy), (idx == ETOT - 1) ? 0 : 1);
          if (neg_first && idx == 0) check("sext_2000", 32'(ss_if.data_o), 32'hE000);
          if (idx == rst_at) begin
            rst = 1'b1;
            #1;
            check_all_zero("midrun_rst");
            @(negedge clk);
            rst = 1'b0;
            ss_if.hold = 1'b0;
            for (int j = 0; j < 5; j++) begin
              @(negedge clk);
              check("post_rst_do_en", 32'(ss_if.do_en), 0);
              check("post_rst_mem_rd", 32'(ss_if.mem_rd), 0);
              check("post_rst_busy", 32'(ss_if.busy), 0);
            end
            return;
          end
          if (idx == start_at) ss_if.start = 1'b1;
          idx++;
        end
      end else if (idx > 0 && idx < ETOT) begin
        check("gap_data_o", 32'(ss_if.data_o), exp_data[idx-1]);
        check("gap_num", 32'(ss_if.num), idx - 1);
        check("gap_busy", 32'(ss_if.busy), 1);
        check("gap_done", 32'(ss_if.done), 0);
      end else if (idx == ETOT) begin
        quiet++;
        check("idle_busy", 32'(ss_if.busy), 0);
      end
      if (hold_pct < 0) begin
        if (ss_if.mem_rd && ss_if.mem_addr == 3) hold_left = 3;
        ss_if.hold = (hold_left > 0);
        if (hold_left > 0) hold_left--;
      end else begin
        ss_if.hold = ($urandom_range(0, 99) < hold_pct);
      end
    end
    check("emit_count", idx, ETOT);
    ss_if.hold = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    ss_if.start    = 1'b0;
    ss_if.hold     = 1'b0;
    ss_if.mem_data = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_do_en", 32'(ss_if.do_en), 0);
    check("idle_mem_rd", 32'(ss_if.mem_rd), 0);

    run_one(0, -1, -1, 1'b0);
    run_one(0, -1, -1, 1'b1);
    run_one(-1, -1, -1, 1'b0);
    run_one(30, -1, -1, 1'b0);
    run_one(60, -1, -1, 1'b1);
    run_one(0, 2, -1, 1'b0);
    run_one(0, -1, 5, 1'b0);
    run_one(0, -1, -1, 1'b0);
    run_one(40, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
